// File: rtl/track_multitap_correlator.sv
// track_multitap_correlator
//
// Multi-tap code correlator for carrier-wiped complex baseband samples.
// NUM_TAPS code replicas are spaced TAP_SPACING valid samples apart. Tap 0 is
// the earliest replica and uses the incoming chip directly. Each tap
// accumulates +/-I and +/-Q over i_length valid samples. All taps are then
// dumped together into the o_i/o_q output registers.
//
// Ports:
//   axis_aclk      clock
//   axis_aresetn   synchronous reset, active-high (despite the name)
//   s_axis_tdata   {Q, I} signed samples, SAMPLE_W each
//   s_axis_tvalid  sample valid (always accepted)
//   i_code_chip    chip for tap 0 (0 => +1, 1 => -1)
//   i_length       samples per integration (0 treated as 1)
//   i_start        pulse: begin integration from IDLE/HOLD
//   i_continuous   level: re-arm after every dump without losing samples
//   i_stop         pulse: abort to IDLE (beats start and dump)
//   i_ack          pulse: host consumed the dump
//   o_i, o_q       dumped sums, tap k at [k*ACC_W +: ACC_W]
//   o_dump_valid   one-cycle pulse when o_i/o_q update
//   o_ready        dump pending until i_ack
//   o_overrun      sticky: dump while o_ready already set
//   o_busy         high while integrating
//   o_sat          (TRACK_CORR_SAT_EN only) some tap saturated, valid with dump
//
// Build option: define TRACK_CORR_SAT_EN for saturating accumulators and the
// o_sat port. Without it, the accumulators wrap in two's complement.
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | stopped, waiting for i_start
// S_INTEG   | accumulating valid samples
// S_HOLD    | single-shot dump done, waiting for i_start

module track_multitap_correlator #(
    parameter int SAMPLE_W    = 16,
    parameter int NUM_TAPS    = 3,
    parameter int TAP_SPACING = 2,
    parameter int ACC_W       = 32,
    parameter int LEN_W       = 32
) (
    input  logic                        axis_aclk,
    input  logic                        axis_aresetn,
    input  logic [2*SAMPLE_W-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        i_code_chip,
    input  logic [LEN_W-1:0]            i_length,
    input  logic                        i_start,
    input  logic                        i_continuous,
    input  logic                        i_stop,
    input  logic                        i_ack,
    output logic [NUM_TAPS*ACC_W-1:0]   o_i,
    output logic [NUM_TAPS*ACC_W-1:0]   o_q,
    output logic                        o_dump_valid,
    output logic                        o_ready,
    output logic                        o_overrun,
`ifdef TRACK_CORR_SAT_EN
    output logic                        o_sat,
`endif
    output logic                        o_busy
);

    localparam int HIST = (NUM_TAPS > 1) ? (NUM_TAPS - 1) * TAP_SPACING : 1;
`ifdef TRACK_CORR_SAT_EN
    // One guard bit so overflow is visible before clamping.
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`else
    localparam int SUM_W = ACC_W;
`endif

    typedef enum logic [1:0] {S_IDLE, S_INTEG, S_HOLD} state_t;

    state_t                    state, state_nx;
    logic [HIST-1:0]           dly;
    logic [HIST:0]             chips;
    logic signed [ACC_W-1:0]   acc_i [NUM_TAPS];
    logic signed [ACC_W-1:0]   acc_q [NUM_TAPS];
    logic signed [ACC_W-1:0]   nxt_i [NUM_TAPS];
    logic signed [ACC_W-1:0]   nxt_q [NUM_TAPS];
    logic [LEN_W-1:0]          cnt, cnt_inc, len_q, len_eff;
    logic                      dump_pend;
    logic                      entering, take, last;
    logic signed [SAMPLE_W-1:0] smp_i, smp_q;
    logic signed [SUM_W-1:0]   ext_i, ext_q;

    assign smp_i   = s_axis_tdata[SAMPLE_W-1:0];
    assign smp_q   = s_axis_tdata[2*SAMPLE_W-1:SAMPLE_W];
    assign ext_i   = SUM_W'(smp_i);
    assign ext_q   = SUM_W'(smp_q);

    // Bit 0 is the current chip, bit n the chip from n valid samples ago.
    assign chips   = {dly, i_code_chip};

    assign len_eff  = (i_length == '0) ? LEN_W'(1) : i_length;
    assign cnt_inc  = cnt + LEN_W'(1);
    assign entering = i_start && !i_stop && (state != S_INTEG);
    assign take     = s_axis_tvalid && !i_stop && (state == S_INTEG);
    assign last     = take && (cnt_inc >= len_q);
    assign o_busy   = (state == S_INTEG);

`ifdef TRACK_CORR_SAT_EN
    logic [NUM_TAPS-1:0] ovf;
    logic                sat_q;
`endif

    // After a dump the accumulator restarts from zero, so the first sample of
    // the next continuous integration lands on a zero base while the old
    // sums move into o_i/o_q on the same edge.
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic signed [SUM_W-1:0] base_i, base_q, sum_i, sum_q;
        assign base_i = dump_pend ? '0 : SUM_W'(acc_i[k]);
        assign base_q = dump_pend ? '0 : SUM_W'(acc_q[k]);
        assign sum_i  = base_i + (chips[k*TAP_SPACING] ? -ext_i : ext_i);
        assign sum_q  = base_q + (chips[k*TAP_SPACING] ? -ext_q : ext_q);
`ifdef TRACK_CORR_SAT_EN
        logic ovf_i, ovf_q;
        assign ovf_i    = sum_i[ACC_W] != sum_i[ACC_W-1];
        assign ovf_q    = sum_q[ACC_W] != sum_q[ACC_W-1];
        assign ovf[k]   = ovf_i | ovf_q;
        assign nxt_i[k] = ovf_i ? (sum_i[ACC_W] ? ACC_MIN : ACC_MAX) : sum_i[ACC_W-1:0];
        assign nxt_q[k] = ovf_q ? (sum_q[ACC_W] ? ACC_MIN : ACC_MAX) : sum_q[ACC_W-1:0];
`else
        assign nxt_i[k] = sum_i;
        assign nxt_q[k] = sum_q;
`endif
    end

    always_comb begin
        state_nx = state;
        if (i_stop) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_HOLD: if (i_start) state_nx = S_INTEG;
                S_INTEG:        if (last && !i_continuous) state_nx = S_HOLD;
                default:        state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_aresetn) begin
            state        <= S_IDLE;
            dly          <= '0;
            cnt          <= '0;
            len_q        <= '0;
            dump_pend    <= 1'b0;
            o_i          <= '0;
            o_q          <= '0;
            o_dump_valid <= 1'b0;
            o_ready      <= 1'b0;
            o_overrun    <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                acc_i[k] <= '0;
                acc_q[k] <= '0;
            end
`ifdef TRACK_CORR_SAT_EN
            sat_q        <= 1'b0;
            o_sat        <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            o_dump_valid <= 1'b0;
            if (i_ack) o_ready <= 1'b0;

            if (i_stop) begin
                dump_pend <= 1'b0;
                cnt       <= '0;
                for (int k = 0; k < NUM_TAPS; k++) begin
                    acc_i[k] <= '0;
                    acc_q[k] <= '0;
                end
`ifdef TRACK_CORR_SAT_EN
                sat_q     <= 1'b0;
`endif
            end else begin
                dump_pend <= last;

                if (dump_pend) begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        o_i[k*ACC_W +: ACC_W] <= acc_i[k];
                        o_q[k*ACC_W +: ACC_W] <= acc_q[k];
                    end
                    o_dump_valid <= 1'b1;
                    o_ready      <= 1'b1;
                    if (o_ready) o_overrun <= 1'b1;
`ifdef TRACK_CORR_SAT_EN
                    o_sat        <= sat_q;
`endif
                end

                if (entering) begin
                    cnt   <= '0;
                    dly   <= '0;
                    len_q <= len_eff;
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        acc_i[k] <= '0;
                        acc_q[k] <= '0;
                    end
`ifdef TRACK_CORR_SAT_EN
                    sat_q <= 1'b0;
`endif
                    if (state == S_IDLE) o_overrun <= 1'b0;
                end else if (take) begin
                    dly <= chips[HIST-1:0];
                    cnt <= last ? '0 : cnt_inc;
                    if (last) len_q <= len_eff;
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        acc_i[k] <= nxt_i[k];
                        acc_q[k] <= nxt_q[k];
                    end
`ifdef TRACK_CORR_SAT_EN
                    sat_q <= (sat_q & !dump_pend) | (|ovf);
`endif
                end else if (dump_pend) begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        acc_i[k] <= '0;
                        acc_q[k] <= '0;
                    end
`ifdef TRACK_CORR_SAT_EN
                    sat_q <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_track_multitap_correlator.sv
// Directed bench for track_multitap_correlator. Three instances share the
// control stimulus: u0 default parameters, u1 with TAP_SPACING=1, u2 with
// 8-bit samples and accumulators (wrap / saturation case).
module tb_track_multitap_correlator;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               tvalid = 1'b0;
    logic signed [15:0] si = '0;
    logic signed [15:0] sq = '0;
    logic               chip = 1'b0;
    logic [31:0]        len = 32'd1;
    logic               start = 1'b0;
    logic               cont = 1'b0;
    logic               stop = 1'b0;
    logic               ack = 1'b0;

    logic [31:0]        td16;
    logic [15:0]        td8;
    assign td16 = {sq, si};
    assign td8  = {sq[7:0], si[7:0]};

    logic [95:0] oi0, oq0, oi1, oq1;
    logic [23:0] oi2, oq2;
    logic dv0, rdy0, ovr0, busy0;
    logic dv1, rdy1, ovr1, busy1;
    logic dv2, rdy2, ovr2, busy2;
`ifdef TRACK_CORR_SAT_EN
    logic sat0, sat1, sat2;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int dc0 = 0;
    int d0;

    always #5 clk = ~clk;

    always @(negedge clk) if (dv0 === 1'b1) dc0++;

    track_multitap_correlator u0 (
        .axis_aclk(clk), .axis_aresetn(rst), .s_axis_tdata(td16), .s_axis_tvalid(tvalid),
        .i_code_chip(chip), .i_length(len), .i_start(start), .i_continuous(cont),
        .i_stop(stop), .i_ack(ack), .o_i(oi0), .o_q(oq0), .o_dump_valid(dv0),
        .o_ready(rdy0), .o_overrun(ovr0),
`ifdef TRACK_CORR_SAT_EN
        .o_sat(sat0),
`endif
        .o_busy(busy0));

    track_multitap_correlator #(.TAP_SPACING(1)) u1 (
        .axis_aclk(clk), .axis_aresetn(rst), .s_axis_tdata(td16), .s_axis_tvalid(tvalid),
        .i_code_chip(chip), .i_length(len), .i_start(start), .i_continuous(cont),
        .i_stop(stop), .i_ack(ack), .o_i(oi1), .o_q(oq1), .o_dump_valid(dv1),
        .o_ready(rdy1), .o_overrun(ovr1),
`ifdef TRACK_CORR_SAT_EN
        .o_sat(sat1),
`endif
        .o_busy(busy1));

    track_multitap_correlator #(.SAMPLE_W(8), .ACC_W(8)) u2 (
        .axis_aclk(clk), .axis_aresetn(rst), .s_axis_tdata(td8), .s_axis_tvalid(tvalid),
        .i_code_chip(chip), .i_length(len), .i_start(start), .i_continuous(cont),
        .i_stop(stop), .i_ack(ack), .o_i(oi2), .o_q(oq2), .o_dump_valid(dv2),
        .o_ready(rdy2), .o_overrun(ovr2),
`ifdef TRACK_CORR_SAT_EN
        .o_sat(sat2),
`endif
        .o_busy(busy2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic signed [63:0] i0(int k);
        return $signed(oi0[k*32 +: 32]);
    endfunction
    function automatic logic signed [63:0] q0(int k);
        return $signed(oq0[k*32 +: 32]);
    endfunction
    function automatic logic signed [63:0] i1(int k);
        return $signed(oi1[k*32 +: 32]);
    endfunction

    initial begin
        // reset
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_busy", busy0, 0);
        chk("rst_ready", rdy0, 0);
        chk("rst_dv", dv0, 0);
        chk("rst_overrun", ovr0, 0);
        chk("rst_oi", i0(1), 0);

        // single shot, length 4
        len = 4; si = 100; sq = -50; chip = 0;
        start = 1; step(); start = 0;
        chk("t1_busy", busy0, 1);
        d0 = dc0;
        tvalid = 1;
        repeat (4) step();
        tvalid = 0;
        chk("t1_early_dv", dv0, 0);
        step();
        chk("t1_dv", dv0, 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t1_oi_tap%0d", k), i0(k), 400);
            chk($sformatf("t1_oq_tap%0d", k), q0(k), -200);
        end
        chk("t1_ready", rdy0, 1);
        chk("t1_hold_busy", busy0, 0);
        step();
        chk("t1_dv_once", dv0, 0);
        chk("t1_dump_count", dc0 - d0, 1);
        ack = 1; step(); ack = 0;
        chk("t1_ack_ready", rdy0, 0);

        // alternating code, signal follows the code
        len = 8;
        start = 1; step(); start = 0;
        tvalid = 1;
        for (int n = 0; n < 8; n++) begin
            chip = n[0];
            si = chip ? -16'sd1 : 16'sd1;
            sq = 0;
            step();
        end
        tvalid = 0; chip = 0;
        step();
        chk("t2_dv1", dv1, 1);
        chk("t2_sp1_tap0", i1(0), 8);
        chk("t2_sp1_tap1", i1(1), -6);
        chk("t2_sp1_tap2", i1(2), 6);
        chk("t2_sp2_tap1", i0(1), 6);
        chk("t2_sp2_tap2", i0(2), 4);
        chk("t2_overrun", ovr0, 0);
        ack = 1; step(); ack = 0;

        // continuous, length 3, 9 back-to-back samples
        len = 3; cont = 1; si = 1; sq = 0; chip = 0;
        start = 1; step(); start = 0;
        d0 = dc0;
        tvalid = 1;
        for (int s = 1; s <= 9; s++) begin
            step();
            chk($sformatf("t3_dv_s%0d", s), dv0, (s == 4 || s == 7) ? 1 : 0);
            if (s == 4 || s == 7) chk($sformatf("t3_tap0_s%0d", s), i0(0), 3);
            if (s == 4) chk("t3_ovr_first", ovr0, 0);
            if (s == 7) chk("t3_ovr_second", ovr0, 1);
        end
        tvalid = 0;
        step();
        chk("t3_dv_third", dv0, 1);
        chk("t3_tap0_third", i0(0), 3);
        step();
        chk("t3_dump_count", dc0 - d0, 3);
        cont = 0;
        stop = 1; step(); stop = 0;
        chk("t3_stop_busy", busy0, 0);

        // stop on the final sample suppresses the dump
        ack = 1; step(); ack = 0;
        len = 2; si = 7;
        start = 1; step(); start = 0;
        chk("t4_ovr_cleared", ovr0, 0);
        tvalid = 1; step();
        stop = 1; step(); stop = 0; tvalid = 0;
        d0 = dc0;
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("t4_no_dv_%0d", s), dv0, 0);
        end
        chk("t4_busy", busy0, 0);
        chk("t4_oi_kept", i0(0), 3);
        chk("t4_dump_count", dc0 - d0, 0);

        // length 0 behaves as 1
        len = 0; si = -9; sq = 5; chip = 0;
        start = 1; step(); start = 0;
        tvalid = 1; step(); tvalid = 0;
        step();
        chk("t5_dv", dv0, 1);
        chk("t5_oi_tap0", i0(0), -9);
        chk("t5_oq_tap0", q0(0), 5);
        chk("t5_oi_tap2", i0(2), -9);

        // most-negative input negated by chip=1
        ack = 1; step(); ack = 0;
        len = 1; si = -16'sd32768; sq = 0; chip = 1;
        start = 1; step(); start = 0;
        tvalid = 1; step(); tvalid = 0; chip = 0;
        step();
        chk("t6_dv", dv0, 1);
        chk("t6_neg_min", i0(0), 32768);

        // 8-bit accumulator: wrap or saturate
        ack = 1; step(); ack = 0;
        len = 4; si = 127; sq = 0; chip = 0;
        start = 1; step(); start = 0;
        tvalid = 1; repeat (4) step(); tvalid = 0;
        step();
        chk("t7_dv2", dv2, 1);
        chk("t7_wide_tap0", i0(0), 508);
`ifdef TRACK_CORR_SAT_EN
        chk("t7_narrow_tap0", $signed(oi2[7:0]), 127);
        chk("t7_sat", sat2, 1);
`else
        chk("t7_narrow_tap0", $signed(oi2[7:0]), -4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/track_multitap_correlator.md
Name: track_multitap_correlator

Overview:
- Parametrised successor to the GPS L1 E/P/L tracking correlator.
- Consumes carrier-wiped complex baseband samples and a per-sample code chip stream, and correlates them against NUM_TAPS code replicas spaced TAP_SPACING samples apart.
- Accumulates each tap over a programmable length and dumps all taps simultaneously into double-buffered output registers.
- Supports single-shot and gapless continuous integration, and sits between the mixer and the tracking-loop software interface.

Parameters:
- SAMPLE_W, 16, signed width of each I and Q input component.
- NUM_TAPS, 3, number of correlator taps (3 = E/P/L; up to 8).
- TAP_SPACING, 2, delay in valid samples between adjacent taps (>=1).
- ACC_W, 32, signed accumulator and output width per component.
- LEN_W, 32, width of the integration length input.

Ports:
- axis_aclk  in  1  sole clock.
- axis_aresetn  in  1  synchronous reset, active-high (asserted when 1).
- s_axis_tdata  in  2*SAMPLE_W  {Q[2*SAMPLE_W-1:SAMPLE_W], I[SAMPLE_W-1:0]}, signed.
- s_axis_tvalid  in  1  sample valid; always accepted (no tready).
- i_code_chip  in  1  code chip for the earliest tap, qualified by s_axis_tvalid; 0 => +1, 1 => -1.
- i_length  in  LEN_W  samples per integration; 0 is treated as 1.
- i_start  in  1  pulse: begin integration.
- i_continuous  in  1  level: re-arm immediately after each dump.
- i_stop  in  1  pulse: abort to IDLE.
- i_ack  in  1  pulse: host has read the dump.
- o_i  out  NUM_TAPS*ACC_W  dumped I sums; tap k at [k*ACC_W +: ACC_W], tap 0 earliest.
- o_q  out  NUM_TAPS*ACC_W  dumped Q sums, same packing.
- o_dump_valid  out  1  one-cycle pulse when o_i/o_q update.
- o_ready  out  1  dump pending (high from dump until i_ack).
- o_overrun  out  1  sticky: a dump occurred while o_ready was already high.
- o_busy  out  1  high in INTEGRATE.

Behaviour:
- Reset: FSM to IDLE; accumulators, delay line, counters, o_i, o_q cleared to 0; o_dump_valid, o_ready, o_overrun, o_busy = 0.
- FSM states: IDLE, INTEGRATE, HOLD.
  - IDLE: i_start -> INTEGRATE. Entering INTEGRATE latches i_length (0 -> 1), clears accumulators and sample counter, and zeroes the code delay line.
  - INTEGRATE: each valid sample shifts i_code_chip into the delay line (depth (NUM_TAPS-1)*TAP_SPACING+1). Tap k uses the chip delayed by k*TAP_SPACING valid samples. acc_i[k] += ±I and acc_q[k] += ±Q; the update is registered one cycle after the valid sample.
  - Dump: on the valid sample where count reaches the latched length, that sample is included. On the next cycle o_i/o_q are loaded with the final sums and o_dump_valid pulses once.
  - After dump: if i_continuous, stay in INTEGRATE with accumulators reloaded directly from that sample boundary (zero samples lost), the delay line preserved, and i_length re-latched. Otherwise go to HOLD.
  - HOLD: i_start -> INTEGRATE (same entry actions as from IDLE).
  - i_stop in any state -> IDLE, accumulators cleared, outputs retained. i_stop has priority over i_start and over a dump in the same cycle; no dump is issued.
- Handshake flags:
  - o_ready sets on the dump cycle and clears on i_ack. If i_ack and a dump coincide, o_ready stays 1.
  - o_overrun sets if a dump occurs while o_ready=1, and clears only on reset or i_start from IDLE.
- Arithmetic: inputs are sign-extended to ACC_W. Negation of the most-negative input is done in ACC_W, so it does not overflow. Without the optional feature, accumulators wrap two's-complement.
- o_busy is 1 exactly in INTEGRATE.
- Samples with s_axis_tvalid=0 change nothing.

Optional Feature:
- Macro: TRACK_CORR_SAT_EN.
- Defined: each accumulator saturates at +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)). A per-integration sticky saturation bit is ORed across taps and reported on an extra output port, o_sat (1 bit), which is valid with o_dump_valid.
- Undefined: wrapping arithmetic; o_sat is absent.

Test Plan:
- Reset with i_length=4 and constant I=100, Q=-50, chip=0, then i_start:
  - Exactly one o_dump_valid, 5 cycles after the first sample.
  - All taps give o_i=400, o_q=-200; o_ready=1; FSM in HOLD.
- Alternating chips 0,1,0,1…, I=1, Q=0, NUM_TAPS=3, TAP_SPACING=1, i_length=8:
  - Tap0 = 8, tap1 = -6, tap2 = 6 (delay-line zero warm-up contributes +1).
- i_continuous=1, i_length=3, 9 back-to-back valid samples of I=1:
  - Three dump pulses, each o_i tap0 = 3; no sample dropped.
  - With no i_ack, o_overrun=1 after the second dump.
- i_stop asserted on the same cycle the final sample would dump:
  - No o_dump_valid; FSM in IDLE; o_i unchanged from the prior dump.
- i_length=0:
  - Dump after a single sample with o_i = that sample's I.
- ACC_W=8, I=127, chip=0, i_length=4:
  - With TRACK_CORR_SAT_EN: o_i=127 and o_sat=1.
  - Without it: o_i = wrapped value 508 mod 256 = -4.
